// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load byte-lane extraction, write-back source select,
// register-file write port and retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic            stall,
    input  logic            flush,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wd,
    output logic [63:0]     instret
);

    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] wd_next;
    logic            we_next;
    logic            retire;
    logic [63:0]     instret_q;

    // Halfword lane ignores addr_lo[0]; misalignment is handled upstream.
    always_comb begin
        ld_b = mem_load_data[{mem_addr_lo, 3'b000} +: 8];
        ld_h = mem_load_data[{mem_addr_lo[1], 4'b0000} +: 16];
        case (mem_funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{(XLEN-16){ld_h[15]}}, ld_h};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_b};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_h};
            default: ld_ext = mem_load_data;
        endcase
    end

    always_comb begin
        case (mem_wb_sel)
            2'b01:   wd_next = ld_ext;
            2'b10:   wd_next = mem_pc_plus4;
            default: wd_next = mem_alu_result;
        endcase
    end

    // x0 writes are suppressed here so the register file never sees them.
    assign we_next = mem_valid & mem_reg_write & (mem_rd != 5'd0);
    assign retire  = ~flush & ~stall & mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_wd    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_wd    <= '0;
        end else if (!stall) begin
            wb_valid <= mem_valid;
            wb_we    <= we_next;
            wb_rd    <= mem_rd;
            wb_wd    <= wd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret_q <= 64'd0;
        else if (retire)
            instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized + directed bench for mem_wb_stage against a behavioural WB model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 0, mem_reg_write = 0;
    logic [4:0]  mem_rd = 0;
    logic [1:0]  mem_wb_sel = 0;
    logic [2:0]  mem_funct3 = 0;
    logic [1:0]  mem_addr_lo = 0;
    logic [31:0] mem_alu_result = 0, mem_load_data = 0, mem_pc_plus4 = 0;
    logic        stall = 0, flush = 0;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic [63:0] instret;

    int checks = 0;
    int failures = 0;

    // expected state
    logic        e_valid, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [63:0] e_inst;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load result from shift/extend arithmetic on the raw word.
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic [31:0] bw, hw;
        bw = (d >> (8 * int'(lo))) & 32'hFF;
        hw = (d >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (bw >= 32'h80) ? bw - 32'h100 : bw;
            3'b001:  return (hw >= 32'h8000) ? hw - 32'h10000 : hw;
            3'b100:  return bw;
            3'b101:  return hw;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd();
        if (mem_wb_sel == 2'b01) return ref_load(mem_load_data, mem_funct3, mem_addr_lo);
        if (mem_wb_sel == 2'b10) return mem_pc_plus4;
        return mem_alu_result;
    endfunction

    task automatic model_reset();
        e_valid = 0; e_we = 0; e_rd = 0; e_wd = 0; e_inst = 0;
    endtask

    task automatic model_edge();
        if (flush) begin
            e_valid = 0; e_we = 0; e_rd = 0; e_wd = 0;
        end else if (!stall) begin
            e_valid = mem_valid;
            e_rd    = mem_rd;
            e_wd    = ref_wd();
            e_we    = mem_valid && mem_reg_write && (mem_rd != 0);
            e_inst  = e_inst + 64'd1 * mem_valid;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(wb_valid), 64'(e_valid));
        chk({tag, ".we"}, 64'(wb_we), 64'(e_we));
        chk({tag, ".rd"}, 64'(wb_rd), 64'(e_rd));
        chk({tag, ".wd"}, 64'(wb_wd), 64'(e_wd));
        chk({tag, ".instret"}, instret, e_inst);
    endtask

    // Inputs are driven at negedge; one call = one rising edge then a check.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                         input logic st, input logic fl);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_addr_lo = lo; mem_alu_result = alu;
        mem_load_data = ld; mem_pc_plus4 = pc; stall = st; flush = fl;
    endtask

    logic [63:0] base;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  los [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] lexp [5] = '{32'hFFFF_FFFE, 32'h0000_00F0, 32'hFFFF_8001,
                              32'h0000_F0FE, 32'h8001_F0FE};

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // Directed loads on 0x8001_F0FE
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 5'd5, 2'b01, f3s[i], los[i], 32'hDEAD, 32'h8001_F0FE, 0, 0, 0);
            cycle("load");
            chk($sformatf("load%0d.const", i), 64'(wb_wd), 64'(lexp[i]));
        end

        // PC+4 source, then x0 destination
        drive(1, 1, 5'd1, 2'b10, 0, 0, 32'h77, 0, 32'h104, 0, 0);
        cycle("pc4");
        chk("pc4.const_wd", 64'(wb_wd), 64'h104);
        chk("pc4.const_we", 64'(wb_we), 64'd1);
        base = instret;
        drive(1, 1, 5'd0, 2'b10, 0, 0, 32'h77, 0, 32'h104, 0, 0);
        cycle("x0");
        chk("x0.we", 64'(wb_we), 64'd0);
        chk("x0.valid", 64'(wb_valid), 64'd1);
        chk("x0.inc", instret, base + 1);

        // Stall: 0x55 to rd3, then hold for 3 cycles with changing inputs
        base = instret;
        drive(1, 1, 5'd3, 2'b00, 0, 0, 32'h55, 0, 0, 0, 0);
        cycle("stall0");
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(7 + i), 2'b00, 0, 0, 32'h1000 + i, 0, 0, 1, 0);
            cycle("stall");
            chk("stall.wd", 64'(wb_wd), 64'h55);
            chk("stall.rd", 64'(wb_rd), 64'd3);
        end
        chk("stall.inc", instret, base + 1);

        // Flush beats stall
        base = instret;
        drive(1, 1, 5'd9, 2'b00, 0, 0, 32'hAB, 0, 0, 1, 1);
        cycle("flushstall");
        chk("flush.valid", 64'(wb_valid), 64'd0);
        chk("flush.we", 64'(wb_we), 64'd0);
        chk("flush.inst", instret, base);

        // Bubble with reg_write set
        drive(0, 1, 5'd4, 2'b00, 0, 0, 32'h12, 0, 0, 0, 0);
        cycle("bubble");
        chk("bubble.we", 64'(wb_we), 64'd0);
        chk("bubble.inst", instret, base);

        // Counter wrap
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        e_inst = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1, 0, 5'd2, 2'b00, 0, 0, 32'h1, 0, 0, 0, 0);
        cycle("wrap");
        chk("wrap.const", instret, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                  2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            cycle("rand");
            if (wb_we) begin
                chk("inv.we_valid", 64'(wb_valid), 64'd1);
                chk("inv.we_rd0", 64'(wb_rd == 0), 64'd0);
            end
        end

        // Asynchronous reset mid-cycle with a write pending
        drive(1, 1, 5'd6, 2'b00, 0, 0, 32'hCAFE, 0, 0, 0, 0);
        cycle("prerst");
        chk("prerst.we", 64'(wb_we), 64'd1);
        #1;
        rst = 1;
        #1;
        model_reset();
        check_all("asyncrst");
        @(posedge clk);
        @(negedge clk);
        check_all("rsthold");
        rst = 0;
        drive(1, 1, 5'd8, 2'b00, 0, 0, 32'h9, 0, 0, 0, 0);
        cycle("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back pipeline stage of the five-stage RISC-V core. It registers the MEM-stage result and sign/zero-extends load data by byte lane. It selects the write-back source and drives the register file's write port directly (`we`, `rd`, `wd`). It also exposes the registered write-back for forwarding and keeps a 64-bit retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  MEM stage holds a real instruction.
- `mem_reg_write`  in  1  instruction writes a destination register.
- `mem_rd`  in  5  destination register index.
- `mem_wb_sel`  in  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 treated as 00.
- `mem_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW.
- `mem_addr_lo`  in  2  byte offset of the load address (ALU result [1:0]).
- `mem_alu_result`  in  32  ALU result.
- `mem_load_data`  in  32  raw aligned word from data memory.
- `mem_pc_plus4`  in  32  PC+4 of the instruction.
- `stall`  in  1  hold the WB register.
- `flush`  in  1  insert a bubble into WB.
- `wb_valid`  out  1  WB holds a real instruction.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  5  register-file write index.
- `wb_wd`  out  32  register-file write data.
- `instret`  out  64  count of retired instructions.

## Operation
- Load extraction is combinational on the MEM inputs:
  - Byte lane `b = mem_load_data[8*addr_lo +: 8]`.
  - Halfword lane `h = mem_load_data[16*addr_lo[1] +: 16]`; `addr_lo[0]` is ignored (misaligned halfwords are not detected here).
  - LB sign-extends `b`; LBU zero-extends `b`; LH sign-extends `h`; LHU zero-extends `h`; LW passes the full word and ignores `addr_lo`.
- Write-back data mux: `wd_next` = ALU result, extracted load, or `pc_plus4` per `mem_wb_sel`.
- Next-state for the WB register:
  - If `flush`: `wb_valid`←0, `wb_we`←0; `wb_rd` and `wb_wd` are don't-care but are cleared to 0.
  - Else if `stall`: all WB registers hold.
  - Else: `wb_valid`←`mem_valid`, `wb_rd`←`mem_rd`, `wb_wd`←`wd_next`, `wb_we`←`mem_valid & mem_reg_write & (mem_rd != 0)`.
- `flush` has priority over `stall`.
- `wb_we` is never 1 while `wb_valid` is 0, and never 1 with `wb_rd` = 0.
- `instret` increments by 1 on each edge where the WB register loads a new valid instruction: `!flush & !stall & mem_valid`.
  - It does not increment on stalled edges, even if `wb_valid` is held at 1.
  - It wraps from 2^64−1 to 0 with no flag.
- All outputs come straight from flops; there is no combinational path from any input to any output.

## Timing
- Latency: MEM inputs sampled at edge N appear on `wb_*` after edge N; the register file writes them at edge N+1.
- Reset: asynchronous assertion immediately forces `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_wd`=0, `instret`=0. Deassertion takes effect at the next edge; the first capture is on the first rising edge with `rst` low.
- Reset during a stall or flush: reset wins and clears all state.
- Simultaneous `stall` and `flush`: behaves as `flush`; the bubble is inserted and `instret` does not increment.
- A stall of any length holds `wb_we` steady, so the register file rewrites the same value each cycle. This is harmless and is intended.

## Test plan
- Reset: assert `rst` mid-cycle with `wb_we`=1 → all outputs 0 before the next edge; `instret`=0.
- Loads: `mem_load_data`=0x8001_F0FE, `wb_sel`=01, valid, `rd`=5.
  - LB, `addr_lo`=0 → `wd`=0xFFFF_FFFE.
  - LBU, `addr_lo`=1 → 0x0000_00F0.
  - LH, `addr_lo`=2 → 0xFFFF_8001.
  - LHU, `addr_lo`=0 → 0x0000_F0FE.
  - LW → 0x8001_F0FE.
- Sources and x0:
  - `wb_sel`=10, `pc_plus4`=0x104, `rd`=1 → `wd`=0x104, `we`=1.
  - Same with `rd`=0 → `we`=0, `wb_valid`=1, `instret` still increments.
- Stall: load ALU result 0x55 (rd=3), then assert `stall` for 3 cycles while changing inputs → outputs hold 0x55/3 for 3 cycles; `instret` rises by 1 total.
- Flush priority: `stall`=1 and `flush`=1 together with `mem_valid`=1 → next cycle `wb_valid`=0, `wb_we`=0, `instret` unchanged.
- Bubble and wrap:
  - `mem_valid`=0 with `reg_write`=1 → `wb_we`=0, no increment.
  - Force `instret` to 2^64−1 via a hierarchical deposit, retire one instruction → `instret`=0.
